// File: rtl/usb_endpi_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | usb_pkg                                                                  |
// | Shared definitions for the USB IN endpoint control block: endpoint state |
// | encoding, CONTROL register bit positions, buffer size default and the    |
// | length saturation helper.                                                |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
package usb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    SENDING = 2'd2,
    WAIT_HS = 2'd3
  } ep_state_t;

  // CONTROL register layout (write side)
  localparam int CTRL_ARM    = 15;
  localparam int CTRL_FLUSH  = 14;
  localparam int CTRL_SETTOG = 13;
  localparam int CTRL_TOG    = 12;
  localparam int CTRL_LEN_HI = 6;
  localparam int CTRL_LEN_LO = 0;

  // Length / pointer width: the LEN field is 7 bits wide
  localparam int LEN_W = 7;

  localparam int MAX_PKT_DEFAULT = 64;

  // Clamp a requested packet length to the buffer size
  function automatic logic [LEN_W-1:0] sat_len(input logic [LEN_W-1:0] req,
                                               input logic [LEN_W-1:0] limit);
    return (req > limit) ? limit : req;
  endfunction

endpackage
`default_nettype wire

// File: rtl/usb_endpi_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | usb_endpi_ctrl_if                                                        |
// | Bundles the CPU I/O bus, the SIE transmit stream, the host handshake     |
// | inputs and the interrupt line of one IN endpoint.                        |
// |   master : CPU/SIE side (drives io_*, tx_start, tx_ready, host_*)        |
// |   slave  : endpoint side (drives io_rdata, tx_*, irq)                    |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
interface usb_endpi_ctrl_if;
  logic [15:0] io_addr;
  logic        io_we;
  logic        io_re;
  logic [15:0] io_wdata;
  logic [15:0] io_rdata;
  logic        tx_start;
  logic        tx_nak;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  tx_data;
  logic        tx_data1;
  logic        tx_done;
  logic        host_ack;
  logic        host_timeout;
  logic        irq;

  modport master (
    output io_addr, io_we, io_re, io_wdata, tx_start, tx_ready,
           host_ack, host_timeout,
    input  io_rdata, tx_nak, tx_valid, tx_data, tx_data1, tx_done, irq
  );

  modport slave (
    input  io_addr, io_we, io_re, io_wdata, tx_start, tx_ready,
           host_ack, host_timeout,
    output io_rdata, tx_nak, tx_valid, tx_data, tx_data1, tx_done, irq
  );
endinterface
`default_nettype wire

// File: rtl/usb_ep_ram.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | usb_ep_ram                                                               |
// | DEPTH-byte packet buffer. 16-bit write port (low byte at the even byte   |
// | address, high byte at the odd one), 8-bit registered read port.          |
// |   clk, reset : clock, synchronous active-high reset (read register only) |
// |   we, waddr, wdata : word write (waddr is a word address)                |
// |   raddr, rdata     : byte read, data valid one cycle after raddr         |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module usb_ep_ram
  import usb_pkg::*;
#(
  parameter  int DEPTH = MAX_PKT_DEFAULT,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-2:0] waddr,
  input  logic [15:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [15:0] mem [0:DEPTH/2-1];
  logic [15:0] rd_word;

  assign rd_word = mem[raddr[AW-1:1]];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // The read register is reset so the transmit byte reads as zero after reset
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata <= 8'h00;
    end else begin
      rdata <= raddr[0] ? rd_word[15:8] : rd_word[7:0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/usb_endpi_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | usb_endpi_ctrl                                                           |
// | CPU-facing control/buffer stage for one USB IN endpoint: CONTROL/DATA    |
// | register decode, packet buffer pointers, transmit FSM, DATA0/1 toggle.   |
// |   clk, reset : clock, synchronous active-high reset                      |
// |   bus        : usb_endpi_ctrl_if.slave (CPU bus, SIE stream, handshake)  |
// | Optional macro USB_ENDPI_IRQ_EN enables the packet-acknowledged irq.     |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module usb_endpi_ctrl
  import usb_pkg::*;
#(
  parameter logic [15:0] ADDR_CONTROL = 16'h5000,
  parameter logic [15:0] ADDR_DATA    = 16'h5002,
  parameter int          MAX_PKT      = MAX_PKT_DEFAULT
) (
  input logic             clk,
  input logic             reset,
  usb_endpi_ctrl_if.slave bus
);

  localparam int              AW      = $clog2(MAX_PKT);
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_PKT);

  ep_state_t        state, state_nxt;
  logic [LEN_W-1:0] wptr, wptr_nxt;
  logic [LEN_W-1:0] len, len_nxt;
  logic [LEN_W-1:0] rptr, rptr_nxt;
  logic             toggle, toggle_nxt;
  logic             acked, acked_nxt;
  logic             valid, valid_nxt;
  logic             data1, data1_nxt;
  logic             nak, nak_nxt;
  logic [15:0]      rdata, rdata_nxt;

  logic             ctrl_sel, data_sel;
  logic             cfg_open, ctrl_wr, data_wr;
  logic             beat, last_byte, done;
  logic [AW-1:0]    raddr;
  logic [15:0]      ctrl_word;
  logic [7:0]       ram_rdata;

  assign ctrl_sel  = (bus.io_addr == ADDR_CONTROL);
  assign data_sel  = (bus.io_addr == ADDR_DATA);
  // In ARMED a coincident tx_start takes the endpoint, so a CONTROL write in
  // that cycle is dropped rather than changing len under the packet.
  assign cfg_open  = (state == IDLE) || ((state == ARMED) && !bus.tx_start);
  assign ctrl_wr   = bus.io_we && ctrl_sel && cfg_open;
  assign data_wr   = bus.io_we && data_sel && (state == IDLE) && (wptr < MAX_LEN);
  assign beat      = (state == SENDING) && valid && bus.tx_ready;
  assign last_byte = (rptr == len - 1'b1);
  assign done      = (state == SENDING) && ((len == '0) || (beat && last_byte));
  assign ctrl_word = {(state != IDLE), acked, 6'b0, toggle, len};

  always_comb begin
    state_nxt  = state;
    wptr_nxt   = wptr;
    len_nxt    = len;
    rptr_nxt   = rptr;
    toggle_nxt = toggle;
    acked_nxt  = acked;
    valid_nxt  = valid;
    data1_nxt  = data1;
    nak_nxt    = 1'b0;
    rdata_nxt  = rdata;
    raddr      = AW'(rptr);

    if (bus.io_re) begin
      rdata_nxt = ctrl_sel ? ctrl_word : 16'h0000;
    end

    // Flush, toggle set and arm all land together; flush only touches wptr
    // and acked, so ordering against arm is automatic.
    if (ctrl_wr) begin
      if (bus.io_wdata[CTRL_FLUSH]) begin
        wptr_nxt  = '0;
        acked_nxt = 1'b0;
      end
      if (bus.io_wdata[CTRL_SETTOG]) begin
        toggle_nxt = bus.io_wdata[CTRL_TOG];
      end
      if (bus.io_wdata[CTRL_ARM]) begin
        len_nxt   = sat_len(bus.io_wdata[CTRL_LEN_HI:CTRL_LEN_LO], MAX_LEN);
        state_nxt = ARMED;
      end
    end

    if (data_wr) begin
      wptr_nxt = wptr + LEN_W'(2);
    end

    case (state)
      IDLE: begin
        nak_nxt = bus.tx_start;
      end
      ARMED: begin
        // Byte 0 is fetched during the start cycle so it is ready on entry
        raddr = '0;
        if (bus.tx_start) begin
          state_nxt = SENDING;
          rptr_nxt  = '0;
          data1_nxt = toggle;
          valid_nxt = 1'b0;
        end
      end
      SENDING: begin
        if (len == '0) begin
          state_nxt = WAIT_HS;
        end else if (!valid) begin
          valid_nxt = 1'b1;
        end else if (beat) begin
          if (last_byte) begin
            valid_nxt = 1'b0;
            state_nxt = WAIT_HS;
          end else begin
            // Fetch the next byte now so it follows back-to-back
            rptr_nxt = rptr + 1'b1;
            raddr    = AW'(rptr + 1'b1);
          end
        end
      end
      WAIT_HS: begin
        if (bus.host_ack) begin
          toggle_nxt = ~toggle;
          acked_nxt  = 1'b1;
          wptr_nxt   = '0;
          state_nxt  = IDLE;
        end else if (bus.host_timeout) begin
          rptr_nxt  = '0;
          state_nxt = ARMED;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      wptr   <= '0;
      len    <= '0;
      rptr   <= '0;
      toggle <= 1'b0;
      acked  <= 1'b0;
      valid  <= 1'b0;
      data1  <= 1'b0;
      nak    <= 1'b0;
      rdata  <= 16'h0000;
    end else begin
      state  <= state_nxt;
      wptr   <= wptr_nxt;
      len    <= len_nxt;
      rptr   <= rptr_nxt;
      toggle <= toggle_nxt;
      acked  <= acked_nxt;
      valid  <= valid_nxt;
      data1  <= data1_nxt;
      nak    <= nak_nxt;
      rdata  <= rdata_nxt;
    end
  end

  usb_ep_ram #(
    .DEPTH (MAX_PKT)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (data_wr),
    .waddr (wptr[AW-1:1]),
    .wdata (bus.io_wdata),
    .raddr (raddr),
    .rdata (ram_rdata)
  );

  assign bus.io_rdata = rdata;
  assign bus.tx_nak   = nak;
  assign bus.tx_valid = valid;
  assign bus.tx_data  = ram_rdata;
  assign bus.tx_data1 = data1;
  assign bus.tx_done  = done;

`ifdef USB_ENDPI_IRQ_EN
  logic irq_q;

  // Set has priority over the CONTROL-read clear
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_q <= 1'b0;
    end else if ((state == WAIT_HS) && bus.host_ack) begin
      irq_q <= 1'b1;
    end else if (bus.io_re && ctrl_sel) begin
      irq_q <= 1'b0;
    end
  end

  assign bus.irq = irq_q;
`else
  assign bus.irq = 1'b0;
`endif

endmodule
`default_nettype wire
